fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_if.sv | 19 +
 rtl/fetch_skid_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch unit and its buffer
package fetch_pkg;
    localparam int INSTR_BYTES     = 4;
    localparam int FETCH_BUF_DEPTH = 2;
    localparam int CNT_W           = $clog2(FETCH_BUF_DEPTH + 1);
    localparam logic [31:0] NOP    = 32'h00000000;
    typedef logic [CNT_W-1:0] buf_cnt_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, redirect and fetched-instruction handshake bundle
interface fetch_if #(parameter int WORD_SIZE = 32);
    logic [WORD_SIZE-1:0] imem_addr;
    logic [WORD_SIZE-1:0] imem_instr;
    logic                 redirect_valid;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_instr;
    logic [WORD_SIZE-1:0] out_pc;
    modport master (
        output imem_addr, out_valid, out_instr, out_pc,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry shift FIFO; slot 0 is always the head so the
// outputs keep their last value once the buffer drains.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  push_instr,
    input  logic [W-1:0]  push_pc,
    output buf_cnt_t      count,
    output logic [W-1:0]  head_instr,
    output logic [W-1:0]  head_pc
);
    logic [W-1:0] instr_q [FETCH_BUF_DEPTH];
    logic [W-1:0] instr_d [FETCH_BUF_DEPTH];
    logic [W-1:0] pc_q    [FETCH_BUF_DEPTH];
    logic [W-1:0] pc_d    [FETCH_BUF_DEPTH];
    buf_cnt_t     count_q, count_d, wr_slot;
    logic         do_pop;

    always_comb begin
        do_pop  = pop && count_q != '0;
        wr_slot = count_q - buf_cnt_t'(do_pop);
        count_d = flush ? '0 : wr_slot + buf_cnt_t'(push);
        instr_d = instr_q;
        pc_d    = pc_q;
        if (!flush) begin
            if (do_pop && count_q == buf_cnt_t'(FETCH_BUF_DEPTH)) begin
                instr_d[0] = instr_q[1];
                pc_d[0]    = pc_q[1];
            end
            // a pop with one entry leaves slot 0 stale, so the head holds
            if (push) begin
                instr_d[wr_slot[0]] = push_instr;
                pc_d[wr_slot[0]]    = push_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            instr_q <= '{default: W'(NOP)};
            pc_q    <= '{default: '0};
        end else begin
            count_q <= count_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign count      = count_q;
    assign head_instr = instr_q[0];
    assign head_pc    = pc_q[0];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/issue control in front of a synchronous instruction memory.
// FETCH_MISALIGN_TRAP_EN adds misalign_err and stalls issue on a misaligned redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    fetch_if.master   bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic      misalign_err
`endif
);
    logic [WORD_SIZE-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d, load_pc;
    logic                 inflight_q, inflight_d, issue, pop, trap_hold;
    buf_cnt_t             count, occ;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                 misalign_q, misalign_d;
`endif

    always_comb begin
        pop = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
        // occupancy after this edge's pop plus the response still in flight
        occ = count - buf_cnt_t'(pop) + buf_cnt_t'(inflight_q);
`ifdef FETCH_MISALIGN_TRAP_EN
        load_pc    = bus.redirect_pc;
        trap_hold  = misalign_q;
        misalign_d = bus.redirect_valid ? |bus.redirect_pc[1:0] : misalign_q;
`else
        load_pc    = bus.redirect_pc & ~WORD_SIZE'(INSTR_BYTES - 1);
        trap_hold  = 1'b0;
`endif
        issue = !bus.redirect_valid && occ < buf_cnt_t'(FETCH_BUF_DEPTH) && !trap_hold;
        pc_d = bus.redirect_valid ? load_pc
             : issue              ? pc_q + WORD_SIZE'(INSTR_BYTES)
             :                      pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    fetch_skid_fifo #(.W(WORD_SIZE)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .push_instr (bus.imem_instr),
        .push_pc    (inflight_pc_q),
        .count      (count),
        .head_instr (bus.out_instr),
        .head_pc    (bus.out_pc)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = count != '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err  = misalign_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a memory that returns
// its address as data; sampling and driving happen on the falling edge.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_if #(.WORD_SIZE(32)) bus ();
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_err;
`endif

    fetch_unit #(.WORD_SIZE(32), .RESET_PC(32'h00000000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.imem_instr <= bus.imem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic stream(input string tag, input int n, input logic [31:0] start);
        logic [31:0] e;
        e = start;
        for (int i = 0; i < n; i++) begin
            chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " pc"}, bus.out_pc, e);
            chk({tag, " instr"}, bus.out_instr, e);
            e += 32'd4;
            tick();
        end
    endtask

    // redirect edge, then two empty cycles before the target reaches the head
    task automatic redirect(input string tag, input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
        chk({tag, " flush+1"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, " flush+2"}, 32'(bus.out_valid), 32'd0);
        tick();
    endtask

    initial begin
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) tick();
        chk("rst valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_pc", bus.out_pc, 32'd0);
        chk("rst out_instr", bus.out_instr, 32'd0);
        chk("rst imem_addr", bus.imem_addr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst misalign", 32'(misalign_err), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("boot rel+1 valid", 32'(bus.out_valid), 32'd0);
        tick();
        stream("boot", 6, 32'h0);

        // head 24, one in flight for 28, PC at 32: stall fills the buffer
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall valid", 32'(bus.out_valid), 32'd1);
            chk("stall head", bus.out_pc, 32'd24);
            chk("stall imem_addr", bus.imem_addr, 32'd32);
        end
        bus.out_ready = 1'b1;
        stream("resume", 5, 32'd24);

        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("full imem_addr", bus.imem_addr, 32'd52);
        bus.out_ready = 1'b1;
        redirect("redir_full", 32'h00000100);
        stream("redir_full", 3, 32'h00000100);

        redirect("redir_pop", 32'h00000200);
        stream("redir_pop", 3, 32'h00000200);

        redirect("wrap", 32'hFFFFFFF8);
        stream("wrap", 4, 32'hFFFFFFF8);

`ifdef FETCH_MISALIGN_TRAP_EN
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00000102;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mis err", 32'(misalign_err), 32'd1);
            chk("mis valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        redirect("mis_clear", 32'h00000200);
        chk("mis cleared", 32'(misalign_err), 32'd0);
        stream("mis_clear", 3, 32'h00000200);
`else
        redirect("align", 32'h00000302);
        stream("align", 2, 32'h00000300);
`endif

        // asynchronous reset between edges drops everything at once
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst valid", 32'(bus.out_valid), 32'd0);
        chk("mid rst out_pc", bus.out_pc, 32'd0);
        chk("mid rst out_instr", bus.out_instr, 32'd0);
        chk("mid rst imem_addr", bus.imem_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2 rel+1 valid", 32'(bus.out_valid), 32'd0);
        tick();
        stream("rst2", 3, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
